// File: rtl/pma_pkg.sv
// Shared types and constants for the PMA region table.
package pma_pkg;

  localparam int MaxPmaRules = 16;

  // Per-rule attribute bits; lock sits on top so [2:0] is the lookup result.
  typedef struct packed {
    logic lock;
    logic executable;
    logic cached;
    logic non_idempotent;
  } pma_attr_t;

  // cfg_sel_i field encoding
  localparam logic [1:0] PMA_SEL_BASE = 2'd0;
  localparam logic [1:0] PMA_SEL_LEN  = 2'd1;
  localparam logic [1:0] PMA_SEL_ATTR = 2'd2;
  localparam logic [1:0] PMA_SEL_CNT  = 2'd3;

endpackage

// File: rtl/pma_rule_match.sv
// Single-rule range compare: len != 0 && base <= addr < base + len.
// The end bound carries one extra bit so a rule touching the top of the
// address space neither wraps nor truncates.
module pma_rule_match #(
  parameter int unsigned AddrWidth = 64
) (
  input  logic [AddrWidth-1:0] base_i,
  input  logic [AddrWidth-1:0] len_i,
  input  logic [AddrWidth-1:0] addr_i,
  output logic                 match_o
);

  logic [AddrWidth:0] end_excl;

  assign end_excl = {1'b0, base_i} + {1'b0, len_i};
  assign match_o  = (len_i != '0) && (addr_i >= base_i) && ({1'b0, addr_i} < end_excl);

endmodule

// File: rtl/pma_region_table.sv
// Runtime-programmable PMA table: NrRules base/length/attr rules, one
// registered lookup per cycle, and a latency-1 config port.
// Optional build macro PMA_HIT_COUNTERS_EN adds a 32-bit saturating hit
// counter per rule, accessed through field select 3.
module pma_region_table
  import pma_pkg::*;
#(
  parameter int unsigned                 NrRules     = 8,
  parameter int unsigned                 AddrWidth   = 64,
  parameter logic [64*MaxPmaRules-1:0]   RstBase     = '0,
  parameter logic [64*MaxPmaRules-1:0]   RstLength   = '0,
  parameter logic [4*MaxPmaRules-1:0]    RstAttr     = '0,
  parameter logic [2:0]                  DefaultAttr = 3'b001,
  localparam int unsigned                IdxW        = (NrRules > 1) ? $clog2(NrRules) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 lookup_valid_i,
  input  logic [AddrWidth-1:0] lookup_addr_i,
  output logic                 lookup_valid_o,
  output logic                 lookup_hit_o,
  output logic [IdxW-1:0]      lookup_idx_o,
  output logic [2:0]           lookup_attr_o,
  input  logic                 cfg_valid_i,
  input  logic                 cfg_we_i,
  input  logic [3:0]           cfg_idx_i,
  input  logic [1:0]           cfg_sel_i,
  input  logic [63:0]          cfg_wdata_i,
  output logic                 cfg_rvalid_o,
  output logic [63:0]          cfg_rdata_o,
  output logic                 cfg_err_o
);

  localparam int Stages = 1;

  logic [NrRules-1:0]   match;
  logic [AddrWidth-1:0] rule_base [NrRules];
  logic [AddrWidth-1:0] rule_len  [NrRules];
  pma_attr_t            rule_attr [NrRules];
`ifdef PMA_HIT_COUNTERS_EN
  logic [31:0]          rule_cnt  [NrRules];
`endif

  logic            hit_d;
  logic [IdxW-1:0] idx_d;
  logic [2:0]      attr_d;
  logic            idx_ok, sel_lock, cfg_err;
  logic [63:0]     rdata_d;
  logic [Stages:0] vld_pipe;

  // Per-rule storage, config write port and range comparator.
  for (genvar i = 0; i < NrRules; i++) begin : g_rule
    logic [AddrWidth-1:0] base_q, len_q;
    pma_attr_t            attr_q;
    logic                 wr_this;

    assign wr_this = cfg_valid_i && cfg_we_i && !cfg_err && (cfg_idx_i == 4'(i));

    // Rule registers: reload from reset parameters, else accept a legal write.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        base_q <= RstBase[64*i +: AddrWidth];
        len_q  <= RstLength[64*i +: AddrWidth];
        attr_q <= pma_attr_t'(RstAttr[4*i +: 4]);
      end else if (wr_this) begin
        case (cfg_sel_i)
          PMA_SEL_BASE: base_q <= cfg_wdata_i[AddrWidth-1:0];
          PMA_SEL_LEN:  len_q  <= cfg_wdata_i[AddrWidth-1:0];
          PMA_SEL_ATTR: attr_q <= pma_attr_t'(cfg_wdata_i[3:0]);
          default: ;
        endcase
      end
    end

`ifdef PMA_HIT_COUNTERS_EN
    logic [31:0] cnt_q;
    // Hit counter: a clear from config beats a same-cycle increment.
    always_ff @(posedge clk_i) begin
      if (rst_i)
        cnt_q <= '0;
      else if (wr_this && (cfg_sel_i == PMA_SEL_CNT))
        cnt_q <= '0;
      else if (lookup_valid_i && hit_d && (idx_d == IdxW'(i)) && (cnt_q != 32'hFFFF_FFFF))
        cnt_q <= cnt_q + 32'd1;
    end
    assign rule_cnt[i] = cnt_q;
`endif

    assign rule_base[i] = base_q;
    assign rule_len[i]  = len_q;
    assign rule_attr[i] = attr_q;

    pma_rule_match #(.AddrWidth(AddrWidth)) u_match (
      .base_i  (base_q),
      .len_i   (len_q),
      .addr_i  (lookup_addr_i),
      .match_o (match[i])
    );
  end

  // Priority encode: scan high to low so the lowest matching index wins.
  always_comb begin
    hit_d  = 1'b0;
    idx_d  = '0;
    attr_d = DefaultAttr;
    for (int i = NrRules - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit_d  = 1'b1;
        idx_d  = IdxW'(i);
        attr_d = {rule_attr[i].executable, rule_attr[i].cached, rule_attr[i].non_idempotent};
      end
    end
  end

  // Config decode: select the addressed rule, form read data and error.
  always_comb begin
    idx_ok   = ({28'd0, cfg_idx_i} < 32'(NrRules));
    sel_lock = 1'b0;
    rdata_d  = '0;
    for (int i = 0; i < NrRules; i++) begin
      if (cfg_idx_i == 4'(i)) begin
        sel_lock = rule_attr[i].lock;
        case (cfg_sel_i)
          PMA_SEL_BASE: rdata_d = 64'(rule_base[i]);
          PMA_SEL_LEN:  rdata_d = 64'(rule_len[i]);
          PMA_SEL_ATTR: rdata_d = 64'(rule_attr[i]);
`ifdef PMA_HIT_COUNTERS_EN
          default:      rdata_d = 64'(rule_cnt[i]);
`else
          default:      rdata_d = '0;
`endif
        endcase
      end
    end
`ifdef PMA_HIT_COUNTERS_EN
    // Counter clears are maintenance, not attribute changes: lock does not block them.
    cfg_err = !idx_ok || (cfg_we_i && sel_lock && (cfg_sel_i != PMA_SEL_CNT));
`else
    cfg_err = !idx_ok || (cfg_sel_i == PMA_SEL_CNT) || (cfg_we_i && sel_lock);
`endif
  end

  assign vld_pipe[0]    = lookup_valid_i;
  assign lookup_valid_o = vld_pipe[Stages];

  // Output registers; lookup fields hold between valid requests.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_pipe[Stages:1] <= '0;
      lookup_hit_o       <= 1'b0;
      lookup_idx_o       <= '0;
      lookup_attr_o      <= '0;
      cfg_rvalid_o       <= 1'b0;
      cfg_rdata_o        <= '0;
      cfg_err_o          <= 1'b0;
    end else begin
      vld_pipe[Stages:1] <= vld_pipe[Stages-1:0];
      if (lookup_valid_i) begin
        lookup_hit_o  <= hit_d;
        lookup_idx_o  <= idx_d;
        lookup_attr_o <= attr_d;
      end
      cfg_rvalid_o <= cfg_valid_i;
      cfg_err_o    <= cfg_valid_i && cfg_err;
      cfg_rdata_o  <= (cfg_valid_i && !cfg_we_i && !cfg_err) ? rdata_d : '0;
    end
  end

endmodule

// File: tb/tb_pma_region_table.sv
// Directed bench for pma_region_table (NrRules = 8, AddrWidth = 64).
module tb_pma_region_table;
  import pma_pkg::*;

  localparam logic [1023:0] TbBase = 1024'h8000_0000;
  localparam logic [1023:0] TbLen  = 1024'h4000_0000;
  localparam logic [63:0]   TbAttr = 64'h6;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        lookup_valid_i;
  logic [63:0] lookup_addr_i;
  logic        lookup_valid_o, lookup_hit_o;
  logic [2:0]  lookup_idx_o, lookup_attr_o;
  logic        cfg_valid_i, cfg_we_i;
  logic [3:0]  cfg_idx_i;
  logic [1:0]  cfg_sel_i;
  logic [63:0] cfg_wdata_i;
  logic        cfg_rvalid_o, cfg_err_o;
  logic [63:0] cfg_rdata_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  pma_region_table #(
    .NrRules(8), .AddrWidth(64),
    .RstBase(TbBase), .RstLength(TbLen), .RstAttr(TbAttr),
    .DefaultAttr(3'b001)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .lookup_valid_i(lookup_valid_i), .lookup_addr_i(lookup_addr_i),
    .lookup_valid_o(lookup_valid_o), .lookup_hit_o(lookup_hit_o),
    .lookup_idx_o(lookup_idx_o), .lookup_attr_o(lookup_attr_o),
    .cfg_valid_i(cfg_valid_i), .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i),
    .cfg_sel_i(cfg_sel_i), .cfg_wdata_i(cfg_wdata_i),
    .cfg_rvalid_o(cfg_rvalid_o), .cfg_rdata_o(cfg_rdata_o), .cfg_err_o(cfg_err_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
    lookup_valid_i = 1'b0;
    cfg_valid_i    = 1'b0;
  endtask

  task automatic lookup(input logic [63:0] a);
    lookup_valid_i = 1'b1;
    lookup_addr_i  = a;
    tick();
  endtask

  task automatic cfg(input logic we, input logic [3:0] idx, input logic [1:0] sel,
                     input logic [63:0] d);
    cfg_valid_i = 1'b1;
    cfg_we_i    = we;
    cfg_idx_i   = idx;
    cfg_sel_i   = sel;
    cfg_wdata_i = d;
    tick();
  endtask

  task automatic chk_lk(input string tag, input logic hit, input logic [2:0] idx,
                        input logic [2:0] attr);
    chk({tag, "_vld"},  64'(lookup_valid_o), 64'd1);
    chk({tag, "_hit"},  64'(lookup_hit_o),   64'(hit));
    chk({tag, "_idx"},  64'(lookup_idx_o),   64'(idx));
    chk({tag, "_attr"}, 64'(lookup_attr_o),  64'(attr));
  endtask

  task automatic chk_cfg(input string tag, input logic err, input logic [63:0] rd);
    chk({tag, "_rv"},  64'(cfg_rvalid_o), 64'd1);
    chk({tag, "_err"}, 64'(cfg_err_o),    64'(err));
    chk({tag, "_rd"},  cfg_rdata_o,       rd);
  endtask

  initial begin
    rst_i = 1'b1; lookup_valid_i = 1'b0; lookup_addr_i = '0;
    cfg_valid_i = 1'b0; cfg_we_i = 1'b0; cfg_idx_i = '0; cfg_sel_i = '0; cfg_wdata_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_lvld", 64'(lookup_valid_o), 64'd0);
    chk("rst_hit",  64'(lookup_hit_o),   64'd0);
    chk("rst_attr", 64'(lookup_attr_o),  64'd0);
    chk("rst_rv",   64'(cfg_rvalid_o),   64'd0);
    chk("rst_rd",   cfg_rdata_o,         64'd0);
    rst_i = 1'b0;

    // Reset-loaded rule 0
    lookup(64'h8000_1000);        chk_lk("rst_rule", 1'b1, 3'd0, 3'b110);
    lookup(64'hC000_0000);        chk_lk("bound",    1'b0, 3'd0, 3'b001);
    lookup(64'h7FFF_FFFF);        chk_lk("below",    1'b0, 3'd0, 3'b001);
    tick();
    chk("idle_vld",  64'(lookup_valid_o), 64'd0);
    chk("idle_hold", 64'(lookup_attr_o),  64'h1);
    cfg(1'b0, 4'd0, PMA_SEL_BASE, '0); chk_cfg("rd_base0", 1'b0, 64'h8000_0000);
    cfg(1'b0, 4'd0, PMA_SEL_ATTR, '0); chk_cfg("rd_attr0", 1'b0, 64'h6);

    // Priority between overlapping rules
    cfg(1'b1, 4'd1, PMA_SEL_BASE, 64'h1000);  chk_cfg("wr_b1", 1'b0, 64'd0);
    cfg(1'b1, 4'd1, PMA_SEL_LEN,  64'h1000);
    cfg(1'b1, 4'd1, PMA_SEL_ATTR, 64'h4);
    cfg(1'b1, 4'd3, PMA_SEL_BASE, 64'h0);
    cfg(1'b1, 4'd3, PMA_SEL_LEN,  64'h10000);
    cfg(1'b1, 4'd3, PMA_SEL_ATTR, 64'h1);     chk_cfg("wr_a3", 1'b0, 64'd0);
    lookup(64'h1800);             chk_lk("prio",    1'b1, 3'd1, 3'b100);
    lookup(64'h2000);             chk_lk("prio_hi", 1'b1, 3'd3, 3'b001);
    lookup(64'h0FFF);             chk_lk("prio_lo", 1'b1, 3'd3, 3'b001);

    // Rule reaching the top of the address space
    cfg(1'b1, 4'd4, PMA_SEL_BASE, 64'hFFFF_FFFF_FFFF_F000);
    cfg(1'b1, 4'd4, PMA_SEL_LEN,  64'h1000);
    cfg(1'b1, 4'd4, PMA_SEL_ATTR, 64'h4);
    lookup(64'hFFFF_FFFF_FFFF_FFFF); chk_lk("top",     1'b1, 3'd4, 3'b100);
    lookup(64'hFFFF_FFFF_FFFF_EFFF); chk_lk("top_low", 1'b0, 3'd0, 3'b001);

    // Lock
    cfg(1'b1, 4'd2, PMA_SEL_BASE, 64'h3000);  chk_cfg("lk_pre",  1'b0, 64'd0);
    cfg(1'b1, 4'd2, PMA_SEL_ATTR, 64'hA);     chk_cfg("lk_set",  1'b0, 64'd0);
    cfg(1'b1, 4'd2, PMA_SEL_BASE, 64'h5000);  chk_cfg("lk_wr",   1'b1, 64'd0);
    cfg(1'b0, 4'd2, PMA_SEL_BASE, '0);        chk_cfg("lk_rdb",  1'b0, 64'h3000);
    cfg(1'b1, 4'd2, PMA_SEL_ATTR, 64'h0);     chk_cfg("lk_clr",  1'b1, 64'd0);
    cfg(1'b0, 4'd2, PMA_SEL_ATTR, '0);        chk_cfg("lk_rda",  1'b0, 64'hA);

    // Range / select errors
    cfg(1'b0, 4'd9, PMA_SEL_BASE, '0);        chk_cfg("oor_rd",  1'b1, 64'd0);
    cfg(1'b1, 4'd8, PMA_SEL_BASE, 64'h77);    chk_cfg("oor_wr",  1'b1, 64'd0);
`ifndef PMA_HIT_COUNTERS_EN
    cfg(1'b0, 4'd0, PMA_SEL_CNT, '0);         chk_cfg("sel3",    1'b1, 64'd0);
`endif

    // Write/lookup collision on rule 4
    cfg_valid_i = 1'b1; cfg_we_i = 1'b1; cfg_idx_i = 4'd4;
    cfg_sel_i = PMA_SEL_LEN; cfg_wdata_i = 64'h0;
    lookup(64'hFFFF_FFFF_FFFF_FFFF); chk_lk("coll_old", 1'b1, 3'd4, 3'b100);
    chk("coll_err", 64'(cfg_err_o), 64'd0);
    lookup(64'hFFFF_FFFF_FFFF_FFFF); chk_lk("coll_new", 1'b0, 3'd0, 3'b001);

`ifdef PMA_HIT_COUNTERS_EN
    cfg(1'b1, 4'd0, PMA_SEL_CNT, '0);         chk_cfg("cnt_clr0", 1'b0, 64'd0);
    repeat (5) lookup(64'h8000_1000);
    cfg(1'b0, 4'd0, PMA_SEL_CNT, '0);         chk_cfg("cnt_5",    1'b0, 64'd5);
    cfg(1'b1, 4'd0, PMA_SEL_CNT, '0);         chk_cfg("cnt_clr",  1'b0, 64'd0);
    cfg(1'b0, 4'd0, PMA_SEL_CNT, '0);         chk_cfg("cnt_0",    1'b0, 64'd0);
    cfg(1'b1, 4'd2, PMA_SEL_CNT, '0);         chk_cfg("cnt_lk",   1'b0, 64'd0);
    force dut.g_rule[0].cnt_q = 32'hFFFF_FFFD;
    #1;
    release dut.g_rule[0].cnt_q;
    repeat (4) lookup(64'h8000_1000);
    cfg(1'b0, 4'd0, PMA_SEL_CNT, '0);         chk_cfg("cnt_sat",  1'b0, 64'hFFFF_FFFF);
`endif

    // Reset mid-operation drops in-flight responses and reloads rules
    lookup_valid_i = 1'b1; lookup_addr_i = 64'h8000_1000;
    cfg_valid_i = 1'b1; cfg_we_i = 1'b0; cfg_idx_i = 4'd0; cfg_sel_i = PMA_SEL_BASE;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("mid_lvld", 64'(lookup_valid_o), 64'd0);
    chk("mid_rv",   64'(cfg_rvalid_o),   64'd0);
    chk("mid_hit",  64'(lookup_hit_o),   64'd0);
    cfg(1'b0, 4'd2, PMA_SEL_ATTR, '0);        chk_cfg("mid_unlk", 1'b0, 64'd0);
    cfg(1'b1, 4'd2, PMA_SEL_BASE, 64'h5000);  chk_cfg("mid_wr",   1'b0, 64'd0);
    lookup(64'h1800);             chk_lk("mid_reload", 1'b0, 3'd0, 3'b001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
